// File: rtl/grf_wport_arb.sv
// -----------------------------------------------------------------------------
// grf_wport_arb
//
// Arbitrates the single register-file write port between the W pipeline stage
// and a multi-cycle unit (MDU). The pipeline cannot be back-pressured, so it
// always owns the port when it writes. MDU results are parked in a two-entry
// ordered buffer and drain through the port in cycles the pipeline leaves free.
//
// A pipeline write to a register that is still buffered cancels the buffered
// entry. The pipeline write is program-later, so the stale MDU value must
// never reach the register file.
//
// If the head entry waits STARVE_LIM cycles, stall_req asks the pipeline to
// leave W idle so that the head can retire.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   pipe_we_i    W-stage write request (never back-pressured)
//   pipe_a3_i    W-stage destination register
//   pipe_wd_i    W-stage write data
//   mdu_valid_i  MDU result valid
//   mdu_a3_i     MDU destination register
//   mdu_wd_i     MDU result data
//   mdu_ready_o  buffer can accept an MDU result this cycle (registered)
//   grf_we_o     register-file write enable
//   grf_a3_o     register-file write address
//   grf_wd_o     register-file write data
//   chk_a_i      decode-stage source register to check
//   chk_hit_o    chk_a_i matches a valid buffered entry
//   stall_req_o  request to idle W next cycle (registered)
//   pend_cnt_o   number of valid buffered entries (registered)
// -----------------------------------------------------------------------------
module grf_wport_arb #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_a3_i,
    input  logic [31:0] pipe_wd_i,

    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_a3_i,
    input  logic [31:0] mdu_wd_i,
    output logic        mdu_ready_o,

    output logic        grf_we_o,
    output logic [4:0]  grf_a3_o,
    output logic [31:0] grf_wd_o,

    input  logic [4:0]  chk_a_i,
    output logic        chk_hit_o,
    output logic        stall_req_o,
    output logic [1:0]  pend_cnt_o
);

    // The wait counter must be able to hold STARVE_LIM itself.
    localparam int unsigned WcntW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [WcntW-1:0] WcntMax = WcntW'(STARVE_LIM);

    typedef struct packed {
        logic             vld;
        logic [4:0]       a3;
        logic [31:0]      wd;
        logic [WcntW-1:0] wcnt;
    } slot_t;

    // Slot 0 is the head. Valid entries are always packed toward the head,
    // so slot 1 is only valid if slot 0 is valid.
    slot_t [1:0] slot_q;
    slot_t [1:0] slot_d;

    logic       pipe_hit;
    logic       head_wr;
    logic [1:0] cancel;
    logic [1:0] keep;
    logic       mdu_accept;
    logic       mdu_store;
    slot_t      new_slot;

    // -------------------------------------------------------------------------
    // Registered status
    // -------------------------------------------------------------------------
    assign pend_cnt_o  = {1'b0, slot_q[0].vld} + {1'b0, slot_q[1].vld};
    assign mdu_ready_o = (pend_cnt_o < 2'd2);
    assign stall_req_o = slot_q[0].vld && (slot_q[0].wcnt == WcntMax);

    always_comb begin
        chk_hit_o = 1'b0;
        if (chk_a_i != 5'd0) begin
            for (int i = 0; i < 2; i++) begin
                if (slot_q[i].vld && (slot_q[i].a3 == chk_a_i)) begin
                    chk_hit_o = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Port arbitration and per-slot fate for this cycle
    // -------------------------------------------------------------------------
    always_comb begin
        // A write to r0 has no architectural effect, so it does not occupy the
        // port and cannot cancel anything.
        pipe_hit = pipe_we_i && (pipe_a3_i != 5'd0);

        // Buffered entries never write while reset is held; reset discards them.
        head_wr  = !reset && !pipe_hit && slot_q[0].vld;

        for (int i = 0; i < 2; i++) begin
            cancel[i] = pipe_hit && slot_q[i].vld && (slot_q[i].a3 == pipe_a3_i);
        end

        keep[0] = slot_q[0].vld && !cancel[0] && !head_wr;
        keep[1] = slot_q[1].vld && !cancel[1];
    end

    always_comb begin
        grf_we_o = 1'b0;
        grf_a3_o = 5'd0;
        grf_wd_o = 32'd0;
        if (pipe_hit) begin
            grf_we_o = 1'b1;
            grf_a3_o = pipe_a3_i;
            grf_wd_o = pipe_wd_i;
        end else if (head_wr) begin
            grf_we_o = 1'b1;
            grf_a3_o = slot_q[0].a3;
            grf_wd_o = slot_q[0].wd;
        end
    end

    // -------------------------------------------------------------------------
    // MDU handshake
    // -------------------------------------------------------------------------
    // The handshake completes even for r0, but such a result is dropped.
    assign mdu_accept = mdu_valid_i && mdu_ready_o && !reset;
    assign mdu_store  = mdu_accept && (mdu_a3_i != 5'd0);

    always_comb begin
        new_slot      = '0;
        new_slot.vld  = 1'b1;
        new_slot.a3   = mdu_a3_i;
        new_slot.wd   = mdu_wd_i;
        new_slot.wcnt = '0;
    end

    // -------------------------------------------------------------------------
    // Next buffer contents: survivors in order, then the newly accepted entry.
    // Acceptance implies at most one entry was held, so at most two result.
    // -------------------------------------------------------------------------
    always_comb begin
        slot_d = '0;

        if (keep[0]) begin
            // Head stays head: it waited another cycle.
            slot_d[0] = slot_q[0];
            if (slot_q[0].wcnt != WcntMax) begin
                slot_d[0].wcnt = slot_q[0].wcnt + WcntW'(1);
            end
            if (keep[1]) begin
                slot_d[1] = slot_q[1];
            end else if (mdu_store) begin
                slot_d[1] = new_slot;
            end
        end else if (keep[1]) begin
            // Tail is promoted and starts its wait from zero.
            slot_d[0]      = slot_q[1];
            slot_d[0].wcnt = '0;
            if (mdu_store) begin
                slot_d[1] = new_slot;
            end
        end else if (mdu_store) begin
            slot_d[0] = new_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: tb/tb_grf_wport_arb.sv
// -----------------------------------------------------------------------------
// tb_grf_wport_arb
//
// Directed scenarios for the write-port arbiter followed by a randomized run
// checked against a queue-based reference model of the MDU buffer.
// -----------------------------------------------------------------------------
module tb_grf_wport_arb;

    localparam int unsigned LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic        mdu_valid;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [4:0]  chk_a;
    logic        chk_hit;
    logic        stall_req;
    logic [1:0]  pend_cnt;

    grf_wport_arb #(
        .STARVE_LIM (LIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we_i   (pipe_we),
        .pipe_a3_i   (pipe_a3),
        .pipe_wd_i   (pipe_wd),
        .mdu_valid_i (mdu_valid),
        .mdu_a3_i    (mdu_a3),
        .mdu_wd_i    (mdu_wd),
        .mdu_ready_o (mdu_ready),
        .grf_we_o    (grf_we),
        .grf_a3_o    (grf_a3),
        .grf_wd_o    (grf_wd),
        .chk_a_i     (chk_a),
        .chk_hit_o   (chk_hit),
        .stall_req_o (stall_req),
        .pend_cnt_o  (pend_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Register file as seen through the DUT write port.
    logic [31:0] dut_rf [32];
    always @(negedge clk) begin
        if (grf_we === 1'b1) dut_rf[grf_a3] = grf_wd;
    end

    // -------------------------------------------------------------------------
    // Reference model: an ordered queue of pending results
    // -------------------------------------------------------------------------
    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        int          wt;
    } ent_t;

    ent_t        mq[$];
    logic        exp_ready;
    logic [1:0]  exp_pend;
    logic        exp_hit;
    logic        exp_stall;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;

    task automatic model_eval();
        exp_ready = (mq.size() < 2);
        exp_pend  = 2'(mq.size());
        exp_hit   = 1'b0;
        foreach (mq[i]) if (chk_a != 5'd0 && mq[i].a3 == chk_a) exp_hit = 1'b1;
        exp_stall = (mq.size() > 0) && (mq[0].wt == LIM);
        exp_we = 1'b0; exp_a3 = 5'd0; exp_wd = 32'd0;
        if (pipe_we && pipe_a3 != 5'd0) begin
            exp_we = 1'b1; exp_a3 = pipe_a3; exp_wd = pipe_wd;
        end else if (!reset && mq.size() > 0) begin
            exp_we = 1'b1; exp_a3 = mq[0].a3; exp_wd = mq[0].wd;
        end
    endtask

    task automatic model_update();
        int   n0;
        bit   head_gone;
        ent_t e;
        if (reset) begin
            mq.delete();
            return;
        end
        n0        = mq.size();
        head_gone = 1'b0;
        if (pipe_we && pipe_a3 != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a3 == pipe_a3) begin
                    mq.delete(i);
                    if (i == 0) head_gone = 1'b1;
                end
            end
        end else if (n0 > 0) begin
            void'(mq.pop_front());
            head_gone = 1'b1;
        end
        if (n0 > 0 && !head_gone) begin
            if (mq[0].wt < LIM) mq[0].wt = mq[0].wt + 1;
        end else if (mq.size() > 0) begin
            mq[0].wt = 0;
        end
        if (mdu_valid && n0 < 2 && mdu_a3 != 5'd0) begin
            e.a3 = mdu_a3; e.wd = mdu_wd; e.wt = 0;
            mq.push_back(e);
        end
    endtask

    // Apply inputs just after a rising edge, then move to the falling edge.
    task automatic set_in(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                          input logic mv, input logic [4:0] ma3, input logic [31:0] mwd,
                          input logic [4:0] chk, input logic rst);
        pipe_we = we; pipe_a3 = a3; pipe_wd = wd;
        mdu_valid = mv; mdu_a3 = ma3; mdu_wd = mwd;
        chk_a = chk; reset = rst;
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 5'd0, 1'b1);
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        n_chk++; if (pend_cnt !== 2'd0) begin n_err++;
            $display("FAIL reset_pend: got %0d want 0", pend_cnt); end
        n_chk++; if (mdu_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready: got %b want 1", mdu_ready); end
        n_chk++; if (chk_hit !== 1'b0 || stall_req !== 1'b0) begin n_err++;
            $display("FAIL reset_hit_stall: got %b%b want 00", chk_hit, stall_req); end
        n_chk++; if (grf_we !== 1'b0) begin n_err++;
            $display("FAIL reset_grf_we: got %b want 0", grf_we); end
        advance();
    endtask

    task automatic test_single_accept();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 1'b0);
        n_chk++; if (grf_we !== 1'b0 || mdu_ready !== 1'b1) begin n_err++;
            $display("FAIL single_nobypass: got we=%b rdy=%b want 0 1", grf_we, mdu_ready); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 1'b0);
        n_chk++; if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd5, 32'h1234}) begin n_err++;
            $display("FAIL single_write: got %b %0d %h want 1 5 1234", grf_we, grf_a3, grf_wd); end
        n_chk++; if (pend_cnt !== 2'd1 || chk_hit !== 1'b1) begin n_err++;
            $display("FAIL single_pend1: got %0d hit=%b want 1 1", pend_cnt, chk_hit); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 1'b0);
        n_chk++; if (pend_cnt !== 2'd0 || grf_we !== 1'b0) begin n_err++;
            $display("FAIL single_drained: got %0d we=%b want 0 0", pend_cnt, grf_we); end
        advance();
    endtask

    task automatic test_starve();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 5'd7, 1'b0);
        advance();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88, 5'd7, 1'b0);
        n_chk++; if (pend_cnt !== 2'd1 || chk_hit !== 1'b1 || stall_req !== 1'b0) begin
            n_err++; $display("FAIL starve_first: got %0d hit=%b st=%b want 1 1 0",
                              pend_cnt, chk_hit, stall_req); end
        advance();
        for (int k = 1; k <= int'(LIM); k++) begin
            set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd7, 1'b0);
            n_chk++; if (stall_req !== (k == int'(LIM))) begin n_err++;
                $display("FAIL starve_wait%0d: got %b want %b", k, stall_req, k == int'(LIM)); end
            if (k == 1) begin
                n_chk++; if (pend_cnt !== 2'd2 || mdu_ready !== 1'b0 || chk_hit !== 1'b1) begin
                    n_err++; $display("FAIL starve_full: got %0d rdy=%b hit=%b want 2 0 1",
                                      pend_cnt, mdu_ready, chk_hit); end
                n_chk++; if (grf_a3 !== 5'd3 || grf_wd !== 32'h33) begin n_err++;
                    $display("FAIL starve_pipe_prio: got %0d %h want 3 33", grf_a3, grf_wd); end
            end
            advance();
        end
        set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd7, 1'b0);
        n_chk++; if (stall_req !== 1'b1) begin n_err++;
            $display("FAIL starve_saturate: got %b want 1", stall_req); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 1'b0);
        n_chk++; if ({grf_we, grf_a3, grf_wd, stall_req} !== {1'b1, 5'd7, 32'h77, 1'b1}) begin
            n_err++; $display("FAIL starve_drain_r7: got %b %0d %h st=%b want 1 7 77 1",
                              grf_we, grf_a3, grf_wd, stall_req); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 1'b0);
        n_chk++; if ({grf_we, grf_a3, grf_wd, stall_req, chk_hit} !==
                     {1'b1, 5'd8, 32'h88, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL starve_drain_r8: got %b %0d %h st=%b hit=%b want 1 8 88 0 0",
                              grf_we, grf_a3, grf_wd, stall_req, chk_hit); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        n_chk++; if (pend_cnt !== 2'd0 || grf_we !== 1'b0) begin n_err++;
            $display("FAIL starve_empty: got %0d we=%b want 0 0", pend_cnt, grf_we); end
        advance();
    endtask

    task automatic test_waw_cancel();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'hAAAA, 5'd9, 1'b0);
        advance();
        set_in(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd9, 1'b0);
        n_chk++; if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd9, 32'hBBBB} || pend_cnt !== 2'd1)
        begin n_err++; $display("FAIL waw_pipe: got %b %0d %h pend=%0d want 1 9 bbbb 1",
                                grf_we, grf_a3, grf_wd, pend_cnt); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 1'b0);
        n_chk++; if (pend_cnt !== 2'd0 || chk_hit !== 1'b0 || grf_we !== 1'b0) begin n_err++;
            $display("FAIL waw_cancelled: got %0d hit=%b we=%b want 0 0 0",
                     pend_cnt, chk_hit, grf_we); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        advance();
        n_chk++; if (dut_rf[9] !== 32'hBBBB) begin n_err++;
            $display("FAIL waw_r9_final: got %h want bbbb", dut_rf[9]); end
    endtask

    task automatic test_zero_dest();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 1'b0);
        n_chk++; if (mdu_ready !== 1'b1 || grf_we !== 1'b0) begin n_err++;
            $display("FAIL zero_offer: got rdy=%b we=%b want 1 0", mdu_ready, grf_we); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        n_chk++; if (pend_cnt !== 2'd0 || grf_we !== 1'b0) begin n_err++;
            $display("FAIL zero_dropped: got %0d we=%b want 0 0", pend_cnt, grf_we); end
        advance();
    endtask

    task automatic test_full_drain();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0, 5'd0, 1'b0);
        advance();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB0, 5'd0, 1'b0);
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 1'b0);
        n_chk++; if (pend_cnt !== 2'd2 || mdu_ready !== 1'b0 || grf_a3 !== 5'd10 ||
                     grf_wd !== 32'hA0) begin n_err++;
            $display("FAIL full_refuse: got %0d rdy=%b %0d %h want 2 0 10 a0",
                     pend_cnt, mdu_ready, grf_a3, grf_wd); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 1'b0);
        n_chk++; if (pend_cnt !== 2'd1 || mdu_ready !== 1'b1 || grf_a3 !== 5'd11) begin
            n_err++; $display("FAIL full_reopen: got %0d rdy=%b a3=%0d want 1 1 11",
                              pend_cnt, mdu_ready, grf_a3); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        n_chk++; if (pend_cnt !== 2'd1 || grf_a3 !== 5'd12 || grf_wd !== 32'hC0) begin
            n_err++; $display("FAIL full_late: got %0d %0d %h want 1 12 c0",
                              pend_cnt, grf_a3, grf_wd); end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        advance();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd13, 32'hD0, 5'd13, 1'b0);
        advance();
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd14, 32'hE0, 5'd13, 1'b0);
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13, 1'b1);
        n_chk++; if (pend_cnt !== 2'd2 || grf_we !== 1'b0) begin n_err++;
            $display("FAIL rstmid_during: got %0d we=%b want 2 0", pend_cnt, grf_we); end
        advance();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13, 1'b0);
            n_chk++; if (pend_cnt !== 2'd0 || grf_we !== 1'b0 || chk_hit !== 1'b0) begin
                n_err++; $display("FAIL rstmid_after%0d: got %0d we=%b hit=%b want 0 0 0",
                                  k, pend_cnt, grf_we, chk_hit); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom,
                   ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom,
                   5'($urandom_range(7)), ($urandom_range(63) == 0));
            n_chk++;
            if ({grf_we, grf_a3, grf_wd, mdu_ready, chk_hit, stall_req, pend_cnt} !==
                {exp_we, exp_a3, exp_wd, exp_ready, exp_hit, exp_stall, exp_pend}) begin
                n_err++;
                $display("FAIL random_c%0d: got we=%b a3=%0d wd=%h rdy=%b hit=%b st=%b pend=%0d want we=%b a3=%0d wd=%h rdy=%b hit=%b st=%b pend=%0d",
                         c, grf_we, grf_a3, grf_wd, mdu_ready, chk_hit, stall_req, pend_cnt,
                         exp_we, exp_a3, exp_wd, exp_ready, exp_hit, exp_stall, exp_pend);
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = 32'd0;
        reset = 1'b1; pipe_we = 1'b0; pipe_a3 = 5'd0; pipe_wd = 32'd0;
        mdu_valid = 1'b0; mdu_a3 = 5'd0; mdu_wd = 32'd0; chk_a = 5'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_accept();
        test_starve();
        test_waw_cancel();
        test_zero_dest();
        test_full_drain();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/grf_wport_arb.md
GRF_WPORT_ARB -- requirements
Module: grf_wport_arb

Interface
REQ-001 Parameter STARVE_LIM, default 4: cycles a buffered MDU entry may wait before stall_req asserts.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 pipe_we  input  1  W-stage write request; cannot be back-pressured.
REQ-005 pipe_a3  input  5  W-stage destination register.
REQ-006 pipe_wd  input  32  W-stage write data.
REQ-007 mdu_valid  input  1  multi-cycle unit result valid.
REQ-008 mdu_a3  input  5  MDU destination register.
REQ-009 mdu_wd  input  32  MDU result data.
REQ-010 mdu_ready  output  1  buffer can accept an MDU result this cycle.
REQ-011 grf_we  output  1  register-file write enable.
REQ-012 grf_a3  output  5  register-file write address.
REQ-013 grf_wd  output  32  register-file write data.
REQ-014 chk_a  input  5  decode-stage source register to check.
REQ-015 chk_hit  output  1  chk_a matches a valid buffered MDU entry.
REQ-016 stall_req  output  1  request to the pipeline to idle W next cycle.
REQ-017 pend_cnt  output  2  number of valid buffered entries (0..2).

Function
REQ-018 Buffer: 2 ordered slots (head, tail), each holding valid bit, a3[4:0], wd[31:0], wait counter.
REQ-019 mdu_ready = (registered pend_cnt < 2); depends on no same-cycle input.
REQ-020 MDU accept occurs when mdu_valid && mdu_ready; accepted entry occupies the first free slot at the next edge.
REQ-021 Accepted entry with mdu_a3 == 0 is discarded: handshake completes, no slot consumed.
REQ-022 No bypass: an accepted entry writes the register file no earlier than the cycle after acceptance.
REQ-023 Pipe priority: if pipe_we && pipe_a3 != 0, then grf_we=1, grf_a3=pipe_a3, grf_wd=pipe_wd, combinationally in the same cycle.
REQ-024 Otherwise, if head valid: grf_we=1, grf_a3/grf_wd=head fields; head retires at the edge and tail shifts to head.
REQ-025 Otherwise grf_we=0, grf_a3=0, grf_wd=0.
REQ-026 WAW cancel: a pipe write whose pipe_a3 (nonzero) equals a valid slot's a3 invalidates that slot at the edge (pipe is program-later); remaining entries compact toward head.
REQ-027 Simultaneous accept, drain and/or cancel in one cycle: all apply; result order preserved; pend_cnt = old - retired - cancelled + accepted (accepted 0 if discarded).
REQ-028 chk_hit = OR over valid slots of (slot.a3 == chk_a); chk_a == 0 gives chk_hit = 0.
REQ-029 Head wait counter increments each cycle head is valid and not retired, saturating at STARVE_LIM; it clears when an entry becomes head.
REQ-030 stall_req = head valid && head wait counter == STARVE_LIM (registered state only).
REQ-031 When stall_req is high and pipe_we is low, head writes that cycle per REQ-024; stall_req deasserts once the waiting entry retires or is cancelled.
REQ-032 pend_cnt equals the registered count of valid slots.

Reset
REQ-033 On reset all slots invalid, wait counters 0; next cycle: pend_cnt=0, mdu_ready=1, chk_hit=0, stall_req=0.
REQ-034 While reset is high, MDU accepts are ignored and no slot state changes; the grf_* outputs still follow REQ-023/025 (the register file clears itself).
REQ-035 Reset mid-operation discards all buffered entries without writing them.

Verification
REQ-036 Idle pipe; MDU a3=5, wd=0x1234 accepted at cycle 0 -> grf_we=1, a3=5, wd=0x1234 at cycle 1; pend_cnt 1->0.
REQ-037 Pipe writes r3 every cycle; MDU delivers r7, r8 -> pend_cnt=2, mdu_ready=0, chk_hit=1 for chk_a=7; stall_req at STARVE_LIM=4 waits; pipe idles -> r7 then r8 written.
REQ-038 Buffered r9=0xAAAA; pipe writes r9=0xBBBB -> slot cancelled, pend_cnt decrements, register r9 never receives 0xAAAA.
REQ-039 MDU a3=0 accepted -> pend_cnt stays 0, no grf write.
REQ-040 Full buffer, same cycle: head drains and MDU offers -> offer refused (mdu_ready=0); next cycle mdu_ready=1 and accepted.
REQ-041 Two entries buffered, reset asserted one cycle -> pend_cnt=0, no grf_we from buffer afterwards.
